// File: rtl/writeback_stage_pkg.sv
// Shared constants and the WB pipeline-register bundle for the writeback stage.
package writeback_stage_pkg;

    localparam int WB_DATA_WIDTH = 64;
    localparam int WB_NUM_REGS   = 32;
    localparam int WB_ZERO_REG   = 31;
    localparam int WB_RD_WIDTH   = 5;

    typedef struct packed {
        logic                     valid;
        logic                     regWrite;
        logic [WB_RD_WIDTH-1:0]   rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_bundle_t;

endpackage

// File: rtl/writeback_stage_wb_enable_decoder.sv
// 5-to-N one-hot decoder with enable; the zero register's cell is tied off so it can never be written.
module wb_enable_decoder
    import writeback_stage_pkg::*;
#(
    parameter int NUM_REGS = WB_NUM_REGS,
    parameter int ZERO_REG = WB_ZERO_REG
) (
    input  logic                   en_i,
    input  logic [WB_RD_WIDTH-1:0] rd_i,
    output logic [NUM_REGS-1:0]    we_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            if (gi == ZERO_REG) begin : g_zero
                assign we_o[gi] = 1'b0;
            end else begin : g_cell
                assign we_o[gi] = en_i & (rd_i == WB_RD_WIDTH'(gi));
            end
        end
    endgenerate

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: registers the MEM result, drives one-hot register-file write enables and counts retirements.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int NUM_REGS   = WB_NUM_REGS,
    parameter int ZERO_REG   = WB_ZERO_REG
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_valid,
    input  logic                   mem_regWrite,
    input  logic                   mem_memToReg,
    input  logic [WB_RD_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]  mem_aluResult,
    input  logic [DATA_WIDTH-1:0]  mem_readData,
    input  logic                   stall,
    input  logic                   flush,
    output logic [NUM_REGS-1:0]    wb_writeEnable,
    output logic [DATA_WIDTH-1:0]  wb_writeData,
    output logic [WB_RD_WIDTH-1:0] wb_rd,
    output logic                   wb_regWrite,
    output logic                   wb_valid,
    output logic [63:0]            retire_count
);

    wb_bundle_t  wb_q, wb_d;
    logic [63:0] retire_count_q, retire_count_d;
    logic        retire;

    // Only the selected result is stored, so the mux sits ahead of the register.
    always_comb begin
        wb_d = wb_q;
        if (flush) begin
            wb_d.valid    = 1'b0;
            wb_d.regWrite = 1'b0;
        end else if (!stall) begin
            wb_d.valid    = mem_valid;
            wb_d.regWrite = mem_regWrite & mem_valid;
            wb_d.rd       = mem_rd;
            wb_d.data     = mem_memToReg ? mem_readData : mem_aluResult;
        end
    end

    assign retire         = wb_q.valid & ~stall;
    assign retire_count_d = retire ? retire_count_q + 64'd1 : retire_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q           <= '0;
            retire_count_q <= '0;
        end else begin
            wb_q           <= wb_d;
            retire_count_q <= retire_count_d;
        end
    end

    assign wb_regWrite  = wb_q.valid & wb_q.regWrite & ~stall
                        & (wb_q.rd != WB_RD_WIDTH'(ZERO_REG));
    assign wb_rd        = wb_q.rd;
    assign wb_valid     = wb_q.valid;
    assign wb_writeData = wb_q.data;
    assign retire_count = retire_count_q;

    wb_enable_decoder #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_dec (
        .en_i (wb_regWrite),
        .rd_i (wb_q.rd),
        .we_o (wb_writeEnable)
    );

endmodule
